// File: rtl/square_painter.sv
// Queued square rasteriser: buffers square requests in a FIFO and walks each
// SIZE x SIZE square one pixel per cycle, gating writes to the visible 160x120 area.
module square_painter #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       plot,
  input  logic [7:0] starting_x,
  input  logic [6:0] starting_y,
  input  logic [2:0] colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] vga_colour,
  output logic       writeEn,
  output logic       busy,
  output logic       full,
  output logic       overflow,
  output logic       done
);

  // state | meaning
  // IDLE  | nothing to draw; pixel outputs hold the last square's final pixel
  // DRAW  | walking the square in bx/by/bc, one pixel per cycle, row-major
  typedef enum logic {IDLE, DRAW} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LAST = 3'(SIZE - 1);

  state_t        state;
  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    bx;
  logic [6:0]    by;
  logic [2:0]    bc;
  logic [2:0]    row, col;
  logic          empty, push, pop, last_pix;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign push     = plot && !full;
  assign last_pix = (row == LAST) && (col == LAST);
  assign pop      = !empty && ((state == IDLE) || last_pix);

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (resetn && push)
      mem[wr_ptr] <= {starting_x, starting_y, colour};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      row      <= '0;
      col      <= '0;
      bx       <= '0;
      by       <= '0;
      bc       <= '0;
      overflow <= 1'b0;
    end else begin
      if (plot && full)
        overflow <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);

      case (state)
        IDLE: begin
          if (pop) begin
            {bx, by, bc} <= mem[rd_ptr];
            row          <= '0;
            col          <= '0;
            state        <= DRAW;
          end
        end
        DRAW: begin
          if (last_pix) begin
            if (pop) begin
              {bx, by, bc} <= mem[rd_ptr];
              row          <= '0;
              col          <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (col == LAST) begin
            col <= '0;
            row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Coordinates wrap naturally at 8 and 7 bits; row/col are left at the last
  // pixel in IDLE, so x/y keep their final values without extra holding logic.
  assign x          = bx + {5'b0, col};
  assign y          = by + {4'b0, row};
  assign vga_colour = bc;
  assign writeEn    = (state == DRAW) && (x <= 8'd159) && (y <= 7'd119);
  assign busy       = (state == DRAW) || !empty;
  assign done       = (state == DRAW) && last_pix && empty;

endmodule

// File: tb/tb_square_painter.sv
// Directed bench for square_painter: a DEPTH=16 instance for drawing behaviour
// and a DEPTH=2 instance sharing the same stimulus for overflow behaviour.
module tb_square_painter;
  localparam int SIZE = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       plot = 1'b0;
  logic [7:0] sx = '0;
  logic [6:0] sy = '0;
  logic [2:0] cl = '0;

  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic [2:0] c_a, c_b;
  logic       we_a, we_b, busy_a, busy_b, full_a, full_b, ovf_a, ovf_b, done_a, done_b;

  square_painter #(.SIZE(SIZE), .DEPTH(16)) dut_a (
    .clk(clk), .resetn(resetn), .plot(plot), .starting_x(sx), .starting_y(sy),
    .colour(cl), .x(x_a), .y(y_a), .vga_colour(c_a), .writeEn(we_a),
    .busy(busy_a), .full(full_a), .overflow(ovf_a), .done(done_a));

  square_painter #(.SIZE(SIZE), .DEPTH(2)) dut_b (
    .clk(clk), .resetn(resetn), .plot(plot), .starting_x(sx), .starting_y(sy),
    .colour(cl), .x(x_b), .y(y_b), .vga_colour(c_b), .writeEn(we_b),
    .busy(busy_b), .full(full_b), .overflow(ovf_b), .done(done_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic [31:0] t;
  } pix_t;

  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  pix_t got_a[$];
  pix_t got_b[$];
  pix_t exp_q[$];
  int   done_cnt = 0;
  int   done_t = 0;
  logic [14:0] done_xy = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pix_t p;
    if (we_a) begin
      p.x = x_a; p.y = y_a; p.c = c_a; p.t = 32'(cyc);
      got_a.push_back(p);
    end
    if (we_b) begin
      p.x = x_b; p.y = y_b; p.c = c_b; p.t = 32'(cyc);
      got_b.push_back(p);
    end
    if (done_a) begin
      done_cnt++;
      done_t  = cyc;
      done_xy = {x_a, y_a};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    got_a.delete();
    got_b.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    plot   = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // Reference raster: on-screen pixels of one square, pixel k shown at t0+k.
  task automatic add_square(input logic [7:0] bx, input logic [6:0] by,
                            input logic [2:0] c, input int t0);
    pix_t p;
    for (int r = 0; r < SIZE; r++)
      for (int k = 0; k < SIZE; k++) begin
        p.x = bx + 8'(k);
        p.y = by + 7'(r);
        p.c = c;
        p.t = 32'(t0 + r * SIZE + k);
        if (p.x <= 8'd159 && p.y <= 7'd119) exp_q.push_back(p);
      end
  endtask

  task automatic wait_idle(input bit use_b, input int budget, output bit ok);
    int n = 0;
    while ((use_b ? busy_b : busy_a) && n < budget) begin
      tick();
      n++;
    end
    ok = !(use_b ? busy_b : busy_a);
  endtask

  task automatic test_reset();
    plot   = 1'b1;
    sx     = 8'd10;
    sy     = 7'd20;
    cl     = 3'b111;
    resetn = 1'b0;
    tick();
    total++;
    if ({x_a, y_a, c_a} !== 18'd0) $display("FAIL reset_pixel got x=%0d y=%0d c=%0d want 0 0 0", x_a, y_a, c_a);
    else passed++;
    total++;
    if ({we_a, busy_a, full_a, ovf_a, done_a} !== 5'b0)
      $display("FAIL reset_flags got we/busy/full/ovf/done=%b want 00000", {we_a, busy_a, full_a, ovf_a, done_a});
    else passed++;
    resetn = 1'b1;
    plot   = 1'b0;
    tick();
    total++;
    if ({busy_a, we_a, busy_b} !== 3'b0) $display("FAIL reset_plot_ignored got busy/we/busy_b=%b want 000", {busy_a, we_a, busy_b});
    else passed++;
  endtask

  task automatic test_single();
    int t0;
    bit ok;
    do_reset();
    clear();
    sx = 8'd10; sy = 7'd112; cl = 3'b100; plot = 1'b1;
    tick();
    plot = 1'b0;
    t0 = cyc;
    add_square(8'd10, 7'd112, 3'b100, t0 + 1);
    wait_idle(1'b0, 100, ok);
    total++;
    if (!ok) $display("FAIL single_timeout got busy=%b want 0", busy_a); else passed++;
    total++;
    if (got_a.size() !== exp_q.size()) $display("FAIL single_count got %0d want %0d", got_a.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_q[i])
        $display("FAIL single_pix[%0d] got x=%0d y=%0d c=%0d t=%0d want x=%0d y=%0d c=%0d t=%0d", i,
                 got_a[i].x, got_a[i].y, got_a[i].c, got_a[i].t, exp_q[i].x, exp_q[i].y, exp_q[i].c, exp_q[i].t);
      else passed++;
    end
    total++;
    if (done_cnt !== 1 || done_t !== t0 + 16 || done_xy !== {8'd13, 7'd115})
      $display("FAIL single_done got cnt=%0d t=%0d xy=%h want 1 %0d %h", done_cnt, done_t, done_xy, t0 + 16, {8'd13, 7'd115});
    else passed++;
    total++;
    if (cyc !== t0 + 17) $display("FAIL single_busy_fall got cycle %0d want %0d", cyc, t0 + 17);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int t0 = 0;
    bit ok;
    do_reset();
    clear();
    for (int i = 0; i < 10; i++) begin
      sx = 8'(10 * (i + 1)); sy = 7'd5; cl = (i % 2 == 1) ? 3'b110 : 3'b100; plot = 1'b1;
      tick();
      if (i == 0) t0 = cyc;
    end
    plot = 1'b0;
    for (int i = 0; i < 10; i++)
      add_square(8'(10 * (i + 1)), 7'd5, (i % 2 == 1) ? 3'b110 : 3'b100, t0 + 1 + 16 * i);
    wait_idle(1'b0, 300, ok);
    total++;
    if (!ok) $display("FAIL b2b_timeout got busy=%b want 0", busy_a); else passed++;
    total++;
    if (got_a.size() !== 160) $display("FAIL b2b_count got %0d want 160", got_a.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_q[i])
        $display("FAIL b2b_pix[%0d] got x=%0d y=%0d c=%0d t=%0d want x=%0d y=%0d c=%0d t=%0d", i,
                 got_a[i].x, got_a[i].y, got_a[i].c, got_a[i].t, exp_q[i].x, exp_q[i].y, exp_q[i].c, exp_q[i].t);
      else passed++;
    end
    total++;
    if (ovf_a !== 1'b0 || done_cnt !== 1) $display("FAIL b2b_ovf_done got ovf=%b done_cnt=%0d want 0 1", ovf_a, done_cnt);
    else passed++;
  endtask

  // Two-entry FIFO: with one square already drawing, three further requests
  // arrive on consecutive edges with no pop in between, so the third is dropped.
  task automatic test_overflow();
    int t0;
    bit ok;
    do_reset();
    clear();
    sx = 8'd20; sy = 7'd30; cl = 3'b011; plot = 1'b1;
    tick();
    plot = 1'b0;
    t0 = cyc;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      sx = 8'(40 + 20 * i); sy = 7'd30; cl = 3'b101; plot = 1'b1;
      tick();
      if (i == 1) begin
        total++;
        if (full_b !== 1'b1 || ovf_b !== 1'b0) $display("FAIL ovf_full got full=%b ovf=%b want 1 0", full_b, ovf_b);
        else passed++;
      end
    end
    plot = 1'b0;
    total++;
    if (ovf_b !== 1'b1 || full_b !== 1'b1) $display("FAIL ovf_set got ovf=%b full=%b want 1 1", ovf_b, full_b);
    else passed++;
    add_square(8'd20, 7'd30, 3'b011, t0 + 1);
    add_square(8'd40, 7'd30, 3'b101, t0 + 17);
    add_square(8'd60, 7'd30, 3'b101, t0 + 33);
    wait_idle(1'b1, 200, ok);
    total++;
    if (!ok) $display("FAIL ovf_timeout got busy=%b want 0", busy_b); else passed++;
    total++;
    if (got_b.size() !== 48) $display("FAIL ovf_count got %0d want 48", got_b.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
      total++;
      if (got_b[i] !== exp_q[i])
        $display("FAIL ovf_pix[%0d] got x=%0d y=%0d c=%0d t=%0d want x=%0d y=%0d c=%0d t=%0d", i,
                 got_b[i].x, got_b[i].y, got_b[i].c, got_b[i].t, exp_q[i].x, exp_q[i].y, exp_q[i].c, exp_q[i].t);
      else passed++;
    end
    repeat (5) tick();
    total++;
    if (ovf_b !== 1'b1) $display("FAIL ovf_sticky got %b want 1", ovf_b); else passed++;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    total++;
    if (ovf_b !== 1'b0) $display("FAIL ovf_cleared got %b want 0", ovf_b); else passed++;
  endtask

  task automatic test_edge_square(input string name, input logic [7:0] bx, input logic [6:0] by,
                                  input logic [2:0] c, input logic [14:0] last_xy);
    int t0;
    bit ok;
    do_reset();
    clear();
    sx = bx; sy = by; cl = c; plot = 1'b1;
    tick();
    plot = 1'b0;
    t0 = cyc;
    add_square(bx, by, c, t0 + 1);
    wait_idle(1'b0, 100, ok);
    total++;
    if (!ok) $display("FAIL %s_timeout got busy=%b want 0", name, busy_a); else passed++;
    total++;
    if (got_a.size() !== 4) $display("FAIL %s_count got %0d want 4", name, got_a.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_q[i])
        $display("FAIL %s_pix[%0d] got x=%0d y=%0d c=%0d t=%0d want x=%0d y=%0d c=%0d t=%0d", name, i,
                 got_a[i].x, got_a[i].y, got_a[i].c, got_a[i].t, exp_q[i].x, exp_q[i].y, exp_q[i].c, exp_q[i].t);
      else passed++;
    end
    total++;
    if (done_cnt !== 1 || done_t !== t0 + 16 || done_xy !== last_xy)
      $display("FAIL %s_done got cnt=%0d t=%0d xy=%h want 1 %0d %h", name, done_cnt, done_t, done_xy, t0 + 16, last_xy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int t0 = 0;
    do_reset();
    clear();
    for (int i = 0; i < 3; i++) begin
      sx = 8'(10 + 20 * i); sy = 7'd10; cl = 3'b001; plot = 1'b1;
      tick();
      if (i == 0) t0 = cyc;
    end
    plot = 1'b0;
    while (cyc < t0 + 6) tick();
    resetn = 1'b0;
    tick();
    total++;
    if ({we_a, busy_a, full_a, done_a} !== 4'b0)
      $display("FAIL mid_reset_flags got we/busy/full/done=%b want 0000", {we_a, busy_a, full_a, done_a});
    else passed++;
    resetn = 1'b1;
    repeat (40) tick();
    total++;
    if (got_a.size() !== 6 || busy_a !== 1'b0)
      $display("FAIL mid_reset_pixels got %0d busy=%b want 6 0", got_a.size(), busy_a);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_edge_square("clip", 8'd158, 7'd118, 3'b010, {8'd161, 7'd121});
    test_edge_square("wrap", 8'd254, 7'd126, 3'b001, {8'd1, 7'd1});
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
